// File: rtl/axi_io_pmp_rd_guard.sv
// axi_io_pmp_rd_guard: AXI4 read-channel IO-PMP guard; allowed ARs are forwarded, denied ARs are
// answered locally with an in-order SLVERR burst.
module axi_io_pmp_rd_guard #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int AR_MISC_W       = 29,
    parameter int NR_ENTRIES      = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DEFAULT_ALLOW   = 0
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cfg_we,
    input  logic [(NR_ENTRIES > 1 ? $clog2(NR_ENTRIES) : 1)-1:0] cfg_idx,
    input  logic [ADDR_WIDTH-3:0]                               cfg_addr,
    input  logic [7:0]                                          cfg_cfg,
    input  logic                                                s_ar_valid,
    output logic                                                s_ar_ready,
    input  logic [ID_WIDTH-1:0]                                 s_ar_id,
    input  logic [ADDR_WIDTH-1:0]                               s_ar_addr,
    input  logic [7:0]                                          s_ar_len,
    input  logic [AR_MISC_W-1:0]                                s_ar_misc,
    output logic                                                m_ar_valid,
    input  logic                                                m_ar_ready,
    output logic [ID_WIDTH-1:0]                                 m_ar_id,
    output logic [ADDR_WIDTH-1:0]                               m_ar_addr,
    output logic [7:0]                                          m_ar_len,
    output logic [AR_MISC_W-1:0]                                m_ar_misc,
    input  logic                                                m_r_valid,
    output logic                                                m_r_ready,
    input  logic [ID_WIDTH-1:0]                                 m_r_id,
    input  logic [DATA_WIDTH-1:0]                               m_r_data,
    input  logic [1:0]                                          m_r_resp,
    input  logic                                                m_r_last,
    output logic                                                s_r_valid,
    input  logic                                                s_r_ready,
    output logic [ID_WIDTH-1:0]                                 s_r_id,
    output logic [DATA_WIDTH-1:0]                               s_r_data,
    output logic [1:0]                                          s_r_resp,
    output logic                                                s_r_last,
    output logic [15:0]                                         deny_count
);
    localparam int PW = ADDR_WIDTH - 2;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, FWD, DRAIN, ERR} state_t;

    state_t state_q, state_d;
    // Only the fields that matter are kept per entry: {L, A[1:0], R}
    logic [3:0]            pmp_cfg_q  [NR_ENTRIES];
    logic [PW-1:0]         pmp_addr_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] hit;
    logic [PW-1:0]         a;
    logic                  allow, hs, inc, dec, err, last_beat, ar_ready_q;
    logic [OW-1:0]         outst_q, outst_d;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, beat_q;
    logic [AR_MISC_W-1:0]  misc_q;
    logic [15:0]           deny_q;
    logic                  unused_bits;

    assign unused_bits = ^{s_ar_addr[1:0], cfg_cfg[6:5], cfg_cfg[2:1]};
    assign a = s_ar_addr[ADDR_WIDTH-1:2];

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_match
        logic [PW-1:0] pa, lo, dc;
        logic [1:0]    mode;
        assign pa   = pmp_addr_q[i];
        assign mode = pmp_cfg_q[i][2:1];
        if (i == 0) begin : g_lo0
            assign lo = '0;
        end else begin : g_lo
            assign lo = pmp_addr_q[i-1];
        end
        // NAPOT: trailing ones plus the zero above them are don't-care bits
        assign dc     = pa ^ (pa + PW'(1));
        assign hit[i] = mode == 2'd1 ? (a >= lo && a < pa) :
                        mode == 2'd2 ? (a == pa) :
                        mode == 2'd3 ? (((a ^ pa) & ~dc) == '0) : 1'b0;
    end

    always_comb begin
        allow = DEFAULT_ALLOW != 0;
        for (int j = NR_ENTRIES - 1; j >= 0; j--)
            if (hit[j]) allow = pmp_cfg_q[j][0];
    end

    assign hs        = s_ar_valid && ar_ready_q;
    assign err       = state_q == ERR;
    assign last_beat = beat_q == len_q;
    assign inc       = state_q == FWD && m_ar_ready;
    assign dec       = m_r_valid && m_r_ready && m_r_last;

    always_comb begin
        state_d = state_q == IDLE  ? (hs ? (allow ? FWD : DRAIN) : IDLE) :
                  state_q == FWD   ? (m_ar_ready ? IDLE : FWD) :
                  state_q == DRAIN ? (outst_q == '0 ? ERR : DRAIN) :
                                     (s_r_ready && last_beat ? IDLE : ERR);
        outst_d = inc == dec ? outst_q : inc ? outst_q + OW'(1) : outst_q - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < NR_ENTRIES; j++) begin
                pmp_cfg_q[j]  <= '0;
                pmp_addr_q[j] <= '0;
            end
        end else if (cfg_we && !pmp_cfg_q[cfg_idx][3]) begin
            pmp_cfg_q[cfg_idx]  <= {cfg_cfg[7], cfg_cfg[4:3], cfg_cfg[0]};
            pmp_addr_q[cfg_idx] <= cfg_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b0;
            outst_q    <= '0;
            beat_q     <= '0;
            deny_q     <= '0;
        end else begin
            state_q    <= state_d;
            outst_q    <= outst_d;
            ar_ready_q <= state_d == IDLE && outst_d < MAX_O;
            if (hs) begin
                id_q   <= s_ar_id;
                addr_q <= s_ar_addr;
                len_q  <= s_ar_len;
                misc_q <= s_ar_misc;
                beat_q <= '0;
            end
            if (err && s_r_ready) beat_q <= beat_q + 8'd1;
            if (err && s_r_ready && last_beat && deny_q != 16'hFFFF) deny_q <= deny_q + 16'd1;
        end
    end

    assign s_ar_ready = ar_ready_q;
    assign m_ar_valid = state_q == FWD;
    assign m_ar_id    = id_q;
    assign m_ar_addr  = addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_misc  = misc_q;
    assign m_r_ready  = !err && s_r_ready;
    assign s_r_valid  = err ? 1'b1 : m_r_valid;
    assign s_r_id     = err ? id_q : m_r_id;
    assign s_r_data   = err ? '0 : m_r_data;
    assign s_r_resp   = err ? 2'b10 : m_r_resp;
    assign s_r_last   = err ? last_beat : m_r_last;
    assign deny_count = deny_q;
endmodule
